demux4x32_hs: RTL and testbench
===============================

# demux4x32_hs

Sequential 1-to-4 router for 32-bit words with valid/ready handshakes. It is the write-direction counterpart of the datapath source multiplexers: one upstream producer, such as the CPU store path, sends a word plus a 2-bit target select. The block registers the word and presents it to exactly one of four downstream consumers (data memory, I/O ports, timer, debug). A per-transfer timeout drops transactions to consumers that never accept and flags an error.

## Interface
Parameters:
- TIMEOUT, default 16: max cycles a held word waits for its target's ready; 0 disables the timeout.
- CNT_W, default 16: width of the completed-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  upstream may transfer this cycle.
- in_data  input  32  upstream word.
- in_sel  input  2  target index 0..3.
- out_valid  output  4  one-hot; bit k is valid toward target k.
- out_ready  input  4  bit k is the ready from target k.
- out_data  output  32  held word, shared by all targets.
- err  output  1  one-cycle pulse: held word dropped on timeout.
- err_sel  output  2  target index of the dropped word; valid when err=1.
- xfer_cnt  output  CNT_W  count of completed downstream transfers; wraps.

## Operation
- States are IDLE and HOLD.
- Upstream transfer: in_valid & in_ready at a rising edge.
- Downstream transfer: out_valid[k] & out_ready[k] at a rising edge.
- IDLE:
  - in_ready=1.
  - On upstream transfer: data_q<=in_data, sel_q<=in_sel, timer<=0, go to HOLD.
- HOLD:
  - out_valid = one-hot(sel_q); out_data = data_q.
  - in_ready = out_ready[sel_q], combinational, so back-to-back streaming is possible.
- HOLD with out_ready[sel_q]=1 (downstream transfer completes):
  - xfer_cnt increments.
  - If in_valid is also high, capture the new word, stay in HOLD, timer<=0.
  - Otherwise go to IDLE.
- HOLD with out_ready[sel_q]=0:
  - If TIMEOUT!=0 and timer==TIMEOUT-1, drop the word: err<=1, err_sel<=sel_q, go to IDLE. in_ready stays 0 that cycle.
  - Otherwise timer increments.
- out_ready bits of non-selected targets are ignored.
- Once out_valid[sel_q] is asserted, data_q and sel_q stay stable until the downstream transfer or the timeout drop.
- Timer width is clog2(TIMEOUT+1); minimum width 1.
- xfer_cnt wraps from 2^CNT_W-1 to 0.
- Dropped words do not increment xfer_cnt.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, out_valid=0, out_data=0, err=0, err_sel=0, xfer_cnt=0, timer=0.
  - in_ready is forced 0 while rst_n=0.
- Reset mid-HOLD discards the held word with no err pulse.
- Latency: a word accepted at edge N shows out_valid and out_data from edge N onward. That is one-cycle register latency; there is no combinational path from in_data to out_data.
- Throughput: one word per cycle when the target holds ready high.
- err is registered. It is high for exactly the cycle after the drop edge and 0 otherwise.
- Timeout occurs at the edge where the word has been presented for TIMEOUT cycles without ready.
- If ready arrives on the same edge as the timeout, ready wins: the transfer completes with no err.

## Structure
- Shared package demux_pkg:
  - state typedef {IDLE, HOLD};
  - constants DATA_W=32, SEL_W=2, N_TGT=4;
  - function onehot4(sel).
- One sub-module, hs_timer: loadable up-counter with a `clear` input and a `hit` output for count==TIMEOUT-1, tied off when TIMEOUT=0.
- The top level holds the FSM, the data/sel registers and xfer_cnt.

## Test plan
- Reset release, then in_sel=2, in_data=0xDEADBEEF, out_ready=4'b0100 → out_valid=4'b0100 and out_data=0xDEADBEEF the next cycle; transfer on the following edge; xfer_cnt=1; return to IDLE.
- Streaming 8 words to target 1 with out_ready[1] held high → in_ready stays 1, one transfer per cycle, xfer_cnt=8, out_valid never multi-hot.
- TIMEOUT=16, out_ready=0 after accepting sel=3 → out_valid[3] high for exactly 16 cycles; err=1 and err_sel=3 for one cycle; xfer_cnt unchanged; state IDLE.
- Ready on the same edge as the timeout → transfer counted, err stays 0.
- Held word for target 0 while only out_ready[1]=1 → no transfer; data_q stable; in_ready=0.
- rst_n pulsed low mid-HOLD (asynchronous, between edges) → out_valid=0 immediately, xfer_cnt=0, no err; a new word is accepted normally after release.
- CNT_W=4: 17 transfers → xfer_cnt=1 (wrap verified).

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 handshake write router.
package demux_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 2;
    localparam int N_TGT  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_TGT-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [N_TGT-1:0] v;
        case (sel)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/demux4x32_hs_timer.sv
// Wait timer for a held word: counts cycles without ready, flags the last allowed cycle.
module hs_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] ONE = TW'(1);

    logic [TW-1:0] r_cnt;

    // Wait counter: clear takes priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign hit = 1'b0;
        end else begin : g_timeout
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
            assign hit = (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/demux4x32_hs.sv
// Registered 1-to-4 router for 32-bit words with valid/ready handshakes,
// per-word timeout drop and a wrapping completed-transfer counter.
module demux4x32_hs
    import demux_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [31:0]       out_data,
    output logic              err,
    output logic [1:0]        err_sel,
    output logic [CNT_W-1:0]  xfer_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [SEL_W-1:0]   r_sel;
    logic               r_err;
    logic [SEL_W-1:0]   r_err_sel;
    logic [CNT_W-1:0]   r_xfer_cnt;

    logic w_tgt_ready;
    logic w_up_xfer;
    logic w_dn_xfer;
    logic w_drop;
    logic w_hit;
    logic w_tmr_en;
    logic w_tmr_clear;

    assign w_tgt_ready = out_ready[r_sel];

    // Next state and handshake decode; ready from the target beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_dn_xfer   = 1'b0;
        w_drop      = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                in_ready = rst_n & w_tgt_ready;
                if (w_tgt_ready) begin
                    w_dn_xfer   = 1'b1;
                    w_state_nxt = in_valid ? HOLD : IDLE;
                end else if (w_hit) begin
                    w_drop      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_en    = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_up_xfer   = in_valid & in_ready;
    assign w_tmr_clear = w_up_xfer | (r_state == IDLE);

    hs_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_tmr_clear),
        .en    (w_tmr_en),
        .hit   (w_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held word and target; only reloaded on an upstream transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= '0;
        end else if (w_up_xfer) begin
            r_data <= in_data;
            r_sel  <= in_sel;
        end else begin
            r_data <= r_data;
            r_sel  <= r_sel;
        end
    end

    // Drop pulse and the target it belonged to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_sel <= '0;
        end else begin
            r_err <= w_drop;
            if (w_drop) begin
                r_err_sel <= r_sel;
            end else begin
                r_err_sel <= r_err_sel;
            end
        end
    end

    // Completed downstream transfers, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_dn_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign out_valid = (r_state == HOLD) ? onehot4(r_sel) : 4'b0000;
    assign out_data  = r_data;
    assign err       = r_err;
    assign err_sel   = r_err_sel;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_demux4x32_hs.sv
// Directed and randomized checks of demux4x32_hs against a transaction-level model.
module tb_demux4x32_hs;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [31:0]   out_data;
    logic          err;
    logic [1:0]    err_sel;
    logic [CW-1:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: the word currently held (if any), cycles it has waited, and totals.
    bit          m_held;
    logic [31:0] m_data;
    logic [1:0]  m_sel;
    int          m_age;
    int          m_cnt;
    bit          m_err;
    logic [1:0]  m_err_sel;

    demux4x32_hs #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .err_sel   (err_sel),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_data = 32'd0; m_sel = 2'd0; m_age = 0;
        m_cnt = 0; m_err = 1'b0; m_err_sel = 2'd0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cyc(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        logic [31:0] exp_ov;
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
        exp_ov = m_held ? (32'd1 << m_sel) : 32'd0;
        chk("in_ready", {31'd0, in_ready}, m_held ? {31'd0, r[m_sel]} : 32'd1);
        chk("out_valid", {28'd0, out_valid}, exp_ov);
        chk("out_data", out_data, m_data);
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (m_err) chk("err_sel", {30'd0, err_sel}, {30'd0, m_err_sel});
        chk("xfer_cnt", {28'd0, xfer_cnt}, 32'(m_cnt));
        @(posedge clk);
        m_err = 1'b0;
        if (m_held) begin
            if (r[m_sel]) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (v) begin
                    m_data = d; m_sel = s; m_age = 0;
                end else begin
                    m_held = 1'b0;
                end
            end else if (TO != 0 && m_age == TO - 1) begin
                m_held = 1'b0; m_err = 1'b1; m_err_sel = m_sel;
            end else begin
                m_age++;
            end
        end else if (v) begin
            m_held = 1'b1; m_data = d; m_sel = s; m_age = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int ov_cnt;
        int err_cnt;
        logic [3:0] r;
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'd0; out_ready = 4'd0;
        model_reset();
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_sel", {30'd0, err_sel}, 32'd0);
        chk("rst_xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word to target 2.
        cyc(1'b1, 2'd2, 32'hDEADBEEF, 4'b0100);
        chk("t1_ov", {28'd0, out_valid}, 32'h4);
        chk("t1_data", out_data, 32'hDEADBEEF);
        cyc(1'b0, 2'd0, 32'd0, 4'b0100);
        chk("t1_cnt", {28'd0, xfer_cnt}, 32'd1);
        cyc(1'b0, 2'd0, 32'd0, 4'b0100);

        // Streaming to target 1.
        for (int i = 0; i < 8; i++) cyc(1'b1, 2'd1, $urandom, 4'b0010);
        cyc(1'b0, 2'd0, 32'd0, 4'b0010);
        chk("stream_cnt", {28'd0, xfer_cnt}, 32'd9);

        // Timeout on target 3.
        cyc(1'b1, 2'd3, 32'h3333_0003, 4'b0000);
        ov_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid[3]) ov_cnt++;
            if (err) err_cnt++;
            cyc(1'b0, 2'd0, 32'd0, 4'b0000);
        end
        chk("to_ov_cycles", 32'(ov_cnt), 32'd16);
        chk("to_err_pulses", 32'(err_cnt), 32'd1);
        chk("to_cnt", {28'd0, xfer_cnt}, 32'd9);

        // Ready arrives on the timeout edge.
        cyc(1'b1, 2'd0, 32'h0000_AAAA, 4'b0000);
        for (int i = 0; i < 15; i++) cyc(1'b0, 2'd0, 32'd0, 4'b0000);
        cyc(1'b0, 2'd0, 32'd0, 4'b0001);
        chk("race_err", {31'd0, err}, 32'd0);
        chk("race_cnt", {28'd0, xfer_cnt}, 32'd10);

        // Non-selected ready is ignored.
        cyc(1'b1, 2'd0, 32'h1234_5678, 4'b0000);
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd2, $urandom, 4'b0010);
        chk("ign_data", out_data, 32'h1234_5678);
        cyc(1'b0, 2'd0, 32'd0, 4'b0001);

        // Asynchronous reset in the middle of a hold.
        cyc(1'b1, 2'd1, 32'hCAFE_F00D, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", {28'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_cnt", {28'd0, xfer_cnt}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap: 17 transfers into a 4-bit counter.
        for (int i = 0; i < 17; i++) cyc(1'b1, 2'd0, $urandom, 4'b0001);
        cyc(1'b0, 2'd0, 32'd0, 4'b0001);
        chk("wrap_cnt", {28'd0, xfer_cnt}, 32'd1);

        // Randomized traffic, alternating busy and sparse-ready phases.
        for (int i = 0; i < 600; i++) begin
            if (((i / 50) % 2) == 1)
                r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            else
                r = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
